// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and defaults for the FIFO write-port arbiter.
// Contents: FSM state enum, default parameter constants, one-hot helper.
package fifo_arb_pkg;

   localparam int unsigned N_DEF         = 4;
   localparam int unsigned DATA_DEF      = 8;
   localparam int unsigned MAX_BURST_DEF = 4;
   localparam int unsigned MAX_N         = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      GAP  = 2'd2
   } state_e;

   // One-hot vector with bit idx set; callers cast down to their own width.
   function automatic logic [MAX_N-1:0] onehot(input int unsigned idx);
      onehot = MAX_N'(1) << idx;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write-port arbiter.
// master: arbiter view (drives ack, grant, w_en, wdata, busy).
// slave : environment view (drives req, wdata_in, full).
interface fifo_wr_arbiter_if
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N    = N_DEF,
   parameter int unsigned DATA = DATA_DEF
) ();

   logic [N-1:0]      req;
   logic [N*DATA-1:0] wdata_in;
   logic              full;
   logic [N-1:0]      ack;
   logic [N-1:0]      grant;
   logic              w_en;
   logic [DATA-1:0]   wdata;
   logic              busy;

   modport master (
      input  req, wdata_in, full,
      output ack, grant, w_en, wdata, busy
   );

   modport slave (
      output req, wdata_in, full,
      input  ack, grant, w_en, wdata, busy
   );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr.
// Ports: req (request vector), ptr (start index), idx (winner), valid (any request).
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N = N_DEF
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [$clog2(N)-1:0] idx,
   output logic                 valid
);

   localparam int unsigned IW = $clog2(N);

   int unsigned      pos;
   logic [IW-1:0]    pos_w;

   // Scan offsets farthest-first so the nearest set request overwrites last.
   always_comb begin
      idx   = '0;
      valid = |req;
      pos   = 0;
      pos_w = '0;
      for (int unsigned k = 0; k < N; k++) begin
         pos = 32'(ptr) + (N - 1 - k);
         if (pos >= N) pos = pos - N;
         pos_w = IW'(pos);
         if (req[pos_w]) idx = pos_w;
      end
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the async-FIFO write port among N wclk-domain requesters.
// Round-robin grants, up to MAX_BURST words per grant, one idle GAP cycle after
// every write so the FIFO's registered full flag is current before the next one.
// Ports: wclk (clock), wrst (sync active-low reset), bus (master modport:
//   req/wdata_in/full in; ack/w_en/wdata combinational, grant registered, busy).
// Build option: FIFO_ARB_PRIO0_EN gives requester 0 strict priority in IDLE.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int unsigned N         = N_DEF,
   parameter int unsigned DATA      = DATA_DEF,
   parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
   input  logic               wclk,
   input  logic               wrst,
   fifo_wr_arbiter_if.master  bus
);

   localparam int unsigned IW = $clog2(N);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   state_e          state_q, state_d;
   logic [IW-1:0]   owner_q, owner_d;
   logic [IW-1:0]   ptr_q,   ptr_d;
   logic [CW-1:0]   cnt_q,   cnt_d;
   logic [N-1:0]    grant_q, grant_d;

   logic [IW-1:0]   rr_idx;
   logic [IW-1:0]   pick_idx;
   logic            pick_valid;
   logic [IW-1:0]   rel_ptr;
   logic            owner_req;
   logic            wr_c;
   logic            rel;
   logic            wr_ok;

   rr_pick #(.N(N)) u_rr_pick (
      .req   (bus.req),
      .ptr   (ptr_q),
      .idx   (rr_idx),
      .valid (pick_valid)
   );

`ifdef FIFO_ARB_PRIO0_EN
   assign pick_idx = bus.req[0] ? '0 : rr_idx;
`else
   assign pick_idx = rr_idx;
`endif

   assign owner_req = bus.req[owner_q];

   // Pointer after release: next index after owner, wrapping at N.
   always_comb begin
      rel_ptr = (owner_q == IW'(N - 1)) ? '0 : owner_q + IW'(1);
`ifdef FIFO_ARB_PRIO0_EN
      // Index 0 is served by priority, so round-robin resumes at 1.
      if (rel_ptr == '0 && owner_q != '0) rel_ptr = IW'(1);
`endif
   end

   // State register.
   always_ff @(posedge wclk) begin
      if (!wrst) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end

   // Next-state and write decision.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      wr_c    = 1'b0;
      rel     = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_valid && !bus.full) begin
               state_d = XFER;
               owner_d = pick_idx;
               grant_d = N'(onehot(32'(pick_idx)));
            end
         end
         XFER: begin
            if (!owner_req) begin
               rel = 1'b1;
            end else if (!bus.full) begin
               wr_c    = 1'b1;
               cnt_d   = cnt_q + CW'(1);
               state_d = GAP;
            end
         end
         GAP: begin
            if (cnt_q == CW'(MAX_BURST) || !owner_req) rel = 1'b1;
            else                                       state_d = XFER;
         end
         default: state_d = IDLE;
      endcase
      if (rel) begin
         state_d = IDLE;
         grant_d = '0;
         cnt_d   = '0;
         ptr_d   = rel_ptr;
      end
   end

   // Reset masks the combinational write so an in-flight word is dropped whole.
   assign wr_ok    = wr_c & wrst;
   assign bus.w_en = wr_ok;
   assign bus.ack  = wr_ok ? grant_q : '0;
   assign bus.grant = grant_q;
   assign bus.busy  = (state_q != IDLE);

   // Owner data mux; zero with no owner or during reset.
   always_comb begin
      bus.wdata = '0;
      if (wrst && |grant_q) begin
         for (int unsigned i = 0; i < N; i++) begin
            if (owner_q == IW'(i)) bus.wdata = bus.wdata_in[i*DATA +: DATA];
         end
      end
   end

endmodule
